ps2_cmd_decoder: RTL and testbench

Receives PS/2 keyboard frames from the board's PS2_CLK/PS2_DAT pins and turns them into game commands for the model stage: jump, duck and start. Handles synchronisation, frame validation (start/parity/stop), timeout recovery, and the E0/F0 prefix protocol. Outputs are registered, in the 50 MHz domain, and drive the model's player-motion logic directly.

---
 rtl/ps2_cmd_decoder_pkg.sv | 31 +++
 rtl/ps2_cmd_if.sv | 22 ++
 rtl/ps2_frame_rx.sv | 124 ++++++++++++
 rtl/ps2_cmd_decoder.sv | 123 ++++++++++++
 tb/tb_ps2_cmd_decoder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_cmd_decoder_pkg.sv
// Shared constants, frame FSM encoding and key-map helpers for the PS/2 command decoder.
package ps2_cmd_decoder_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] KEY_JUMP  = 8'h29;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_START = 8'h5A;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    function automatic logic key_is_jump(input logic [7:0] code, input logic ext);
        return (code == KEY_JUMP && !ext) || (code == KEY_UP && ext);
    endfunction

    function automatic logic key_is_duck(input logic [7:0] code, input logic ext);
        return code == KEY_DOWN && ext;
    endfunction

    function automatic logic key_is_start(input logic [7:0] code, input logic ext);
        return code == KEY_START && !ext;
    endfunction

endpackage

// File: rtl/ps2_cmd_if.sv
// Command bus from the PS/2 decoder to the game model stage.
interface ps2_cmd_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       scan_ext;
    logic       scan_brk;
    logic       jump_pulse;
    logic       jump_held;
    logic       duck_held;
    logic       start_pulse;
    logic       frame_err;

    modport master (
        output scan_code, scan_valid, scan_ext, scan_brk,
        output jump_pulse, jump_held, duck_held, start_pulse, frame_err
    );

    modport slave (
        input scan_code, scan_valid, scan_ext, scan_brk,
        input jump_pulse, jump_held, duck_held, start_pulse, frame_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, frame FSM with odd-parity
// check and mid-frame timeout. byte_valid/byte_err are single-cycle strobes.
module ps2_frame_rx
    import ps2_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  filt_q, filt_d, fall;

    rx_state_e             state_q, state_d;
    logic [7:0]            shift_q;
    logic [2:0]            bit_cnt_q;
    logic                  parity_q;
    logic [TW-1:0]         tmo_q;
    logic                  timeout;

    // Synchronisers and filter idle high so reset never fakes a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            hist_q   <= '1;
            filt_q   <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
            hist_q   <= {hist_q[FILTER_LEN-2:0], clk_s2_q};
            filt_q   <= filt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        if (&hist_q) begin
            filt_d = 1'b1;
        end else if (~|hist_q) begin
            filt_d = 1'b0;
        end
    end

    assign fall    = filt_q & ~filt_d;
    assign timeout = (state_q != StIdle) && (tmo_q == TMO_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else if (fall) begin
            case (state_q)
                StIdle:   if (!dat_s2_q) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        if (timeout) begin
            byte_err = 1'b1;
        end else if (fall && state_q == StStop) begin
            if (dat_s2_q && ((^shift_q) ^ parity_q)) begin
                byte_valid = 1'b1;
            end else begin
                byte_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
        end else begin
            tmo_q <= (state_q == StIdle || fall) ? '0 : tmo_q + TW'(1);
            if (fall && !timeout) begin
                case (state_q)
                    StIdle: bit_cnt_q <= '0;
                    StData: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    StParity: parity_q <= dat_s2_q;
                    default:  ;
                endcase
            end
        end
    end

    assign data_byte = shift_q;

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 keyboard to game-command decoder: resolves E0/F0 prefixes and maps keys to
// registered jump/duck/start commands on the model-facing command bus.
module ps2_cmd_decoder
    import ps2_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    ps2_cmd_if.master cmd
);

    logic [7:0] data_byte;
    logic       byte_valid, byte_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) u_frame_rx (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .data_byte (data_byte),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    logic       ext_q, ext_d, brk_q, brk_d;
    logic [7:0] code_q, code_d;
    logic       valid_q, valid_d, sext_q, sext_d, sbrk_q, sbrk_d;
    logic       jp_q, jp_d, jh_q, jh_d, dh_q, dh_d, sp_q, sp_d, err_q, err_d;
    logic       is_jump, is_duck, is_start;

    assign is_jump  = key_is_jump(data_byte, ext_q);
    assign is_duck  = key_is_duck(data_byte, ext_q);
    assign is_start = key_is_start(data_byte, ext_q);

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        code_d  = code_q;
        valid_d = 1'b0;
        sext_d  = sext_q;
        sbrk_d  = sbrk_q;
        jp_d    = 1'b0;
        jh_d    = jh_q;
        dh_d    = dh_q;
        sp_d    = 1'b0;
        err_d   = byte_err;
        if (byte_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            if (data_byte == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (data_byte == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                code_d  = data_byte;
                sext_d  = ext_q;
                sbrk_d  = brk_q;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                if (brk_q) begin
                    if (is_jump) jh_d = 1'b0;
                    if (is_duck) dh_d = 1'b0;
                end else begin
                    // Typematic repeats re-assert held without a fresh pulse.
                    if (is_jump) begin
                        jh_d = 1'b1;
                        jp_d = ~jh_q;
                    end
                    if (is_duck) dh_d = 1'b1;
                    sp_d = is_start;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            code_q  <= '0;
            valid_q <= 1'b0;
            sext_q  <= 1'b0;
            sbrk_q  <= 1'b0;
            jp_q    <= 1'b0;
            jh_q    <= 1'b0;
            dh_q    <= 1'b0;
            sp_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            sext_q  <= sext_d;
            sbrk_q  <= sbrk_d;
            jp_q    <= jp_d;
            jh_q    <= jh_d;
            dh_q    <= dh_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    assign cmd.scan_code   = code_q;
    assign cmd.scan_valid  = valid_q;
    assign cmd.scan_ext    = sext_q;
    assign cmd.scan_brk    = sbrk_q;
    assign cmd.jump_pulse  = jp_q;
    assign cmd.jump_held   = jh_q;
    assign cmd.duck_held   = dh_q;
    assign cmd.start_pulse = sp_q;
    assign cmd.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Directed bench for ps2_cmd_decoder: an event-queue key model checked against the command
// bus every cycle, plus literal checks on latency, counts and reset behaviour.
module tb_ps2_cmd_decoder;

    localparam int unsigned TMO  = 200;
    localparam int unsigned FL   = 3;
    localparam int          HALF = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_cmd_if cmd_bus ();

    ps2_cmd_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FL)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .cmd    (cmd_bus)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic       err;
        logic [7:0] code;
        logic       ext, brk, jp, sp, jh, dh;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic m_ext = 0, m_brk = 0, m_jh = 0, m_dh = 0;
    logic chk_jh = 0, chk_dh = 0;
    int   n_valid = 0, n_jump = 0, n_start = 0, n_err = 0;
    logic [7:0] last_code = 0;
    logic last_ext = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Key model: what each received byte must produce, from the key-map rules.
    task automatic apply_byte(input logic [7:0] d);
        ev_t  e;
        logic j, k, s;
        if (d == 8'hE0) m_ext = 1;
        else if (d == 8'hF0) m_brk = 1;
        else begin
            j = (d == 8'h29 && !m_ext) || (d == 8'h75 && m_ext);
            k = (d == 8'h72 && m_ext);
            s = (d == 8'h5A && !m_ext);
            e.err = 0; e.code = d; e.ext = m_ext; e.brk = m_brk; e.jp = 0; e.sp = 0;
            if (m_brk) begin
                if (j) m_jh = 0;
                if (k) m_dh = 0;
            end else begin
                e.jp = j && !m_jh;
                if (j) m_jh = 1;
                if (k) m_dh = 1;
                e.sp = s;
            end
            e.jh = m_jh; e.dh = m_dh;
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic push_err();
        ev_t e;
        e.err = 1; e.code = 0; e.ext = 0; e.brk = 0; e.jp = 0; e.sp = 0;
        e.jh = m_jh; e.dh = m_dh;
        exp_q.push_back(e);
        m_ext = 0; m_brk = 0;
    endtask

    // Compare process: every output activity cycle must match the next model event.
    initial begin
        ev_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                chk_jh = 0;
                chk_dh = 0;
            end else begin
                if (cmd_bus.scan_valid || cmd_bus.frame_err || cmd_bus.jump_pulse ||
                    cmd_bus.start_pulse) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: valid=%0b err=%0b code=%0h, expected idle",
                                 cmd_bus.scan_valid, cmd_bus.frame_err, cmd_bus.scan_code);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_err", cmd_bus.frame_err, e.err);
                        check("scan_valid", cmd_bus.scan_valid, !e.err);
                        if (!e.err) begin
                            check("scan_code", cmd_bus.scan_code, e.code);
                            check("scan_ext", cmd_bus.scan_ext, e.ext);
                            check("scan_brk", cmd_bus.scan_brk, e.brk);
                        end
                        check("jump_pulse", cmd_bus.jump_pulse, e.jp);
                        check("start_pulse", cmd_bus.start_pulse, e.sp);
                        chk_jh = e.jh;
                        chk_dh = e.dh;
                    end
                    n_valid += int'(cmd_bus.scan_valid);
                    n_jump  += int'(cmd_bus.jump_pulse);
                    n_start += int'(cmd_bus.start_pulse);
                    n_err   += int'(cmd_bus.frame_err);
                    if (cmd_bus.scan_valid) begin
                        last_code = cmd_bus.scan_code;
                        last_ext  = cmd_bus.scan_ext;
                    end
                end
                check("jump_held", cmd_bus.jump_held, chk_jh);
                check("duck_held", cmd_bus.duck_held, chk_dh);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_neg(HALF);
        ps2_clk = 0;
        wait_neg(HALF);
        ps2_clk = 1;
    endtask

    // Posedges from now until any output activity; -1 if none within limit.
    task automatic measure(output int n, input int limit);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clock);
            #1;
            if (cmd_bus.scan_valid || cmd_bus.frame_err) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, output int lat);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~(^d) ^ flip);
        ps2_dat = 1;
        wait_neg(HALF);
        ps2_clk = 0;
        fork
            begin
                wait_neg(HALF);
                ps2_clk = 1;
                wait_neg(2 * HALF);
            end
            measure(lat, 30);
        join
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int lat;
        apply_byte(d);
        send_frame(d, 1'b0, lat);
        drain();
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        m_ext = 0; m_brk = 0; m_jh = 0; m_dh = 0;
    endtask

    initial begin
        int lat;
        wait_neg(5);
        reset = 0;
        @(posedge clock);
        #1;
        check("rst_scan_code", cmd_bus.scan_code, 0);
        check("rst_scan_valid", cmd_bus.scan_valid, 0);
        check("rst_scan_ext", cmd_bus.scan_ext, 0);
        check("rst_scan_brk", cmd_bus.scan_brk, 0);
        check("rst_jump_pulse", cmd_bus.jump_pulse, 0);
        check("rst_jump_held", cmd_bus.jump_held, 0);
        check("rst_duck_held", cmd_bus.duck_held, 0);
        check("rst_start_pulse", cmd_bus.start_pulse, 0);
        check("rst_frame_err", cmd_bus.frame_err, 0);
        wait_neg(4 * HALF);

        // First space press: output lands 2 sync + 3 filter + 1 register posedges after the pin.
        apply_byte(8'h29);
        send_frame(8'h29, 1'b0, lat);
        drain();
        check("stop_to_valid_latency", lat, 6);
        check("first_jump_pulses", n_jump, 1);
        check("first_jump_held", cmd_bus.jump_held, 1);

        repeat (3) send_byte(8'h29);
        check("typematic_valid_count", n_valid, 4);
        check("typematic_jump_pulses", n_jump, 1);

        send_byte(8'hF0);
        send_byte(8'h29);
        check("release_jump_held", cmd_bus.jump_held, 0);
        check("release_valid_count", n_valid, 5);

        send_byte(8'hE0);
        send_byte(8'h72);
        check("down_duck_held", cmd_bus.duck_held, 1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h72);
        check("up_duck_held", cmd_bus.duck_held, 0);
        check("prefix_valid_count", n_valid, 7);

        push_err();
        send_frame(8'h5A, 1'b1, lat);
        drain();
        check("parity_err_count", n_err, 1);
        check("parity_no_start", n_start, 0);
        check("parity_valid_count", n_valid, 7);
        send_byte(8'h5A);
        check("start_pulses", n_start, 1);

        // Abandon a frame after four data bits; the line then idles high.
        push_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        ps2_dat = 1'b0;
        wait_neg(HALF);
        ps2_clk = 0;
        fork
            begin
                wait_neg(HALF);
                ps2_clk = 1;
            end
            measure(lat, int'(TMO) + 60);
        join
        check("timeout_window", (lat >= int'(TMO)) && (lat <= int'(TMO) + 40), 1);
        drain();
        check("timeout_err_count", n_err, 2);
        send_byte(8'h29);
        check("post_timeout_jump", n_jump, 2);

        // Reset mid-frame after an E0 prefix: the prefix and partial frame are dropped.
        send_byte(8'hE0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_dat = 1;
        pulse_reset();
        wait_neg(2 * HALF);
        send_byte(8'h75);
        check("reset_code", last_code, 8'h75);
        check("reset_ext", last_ext, 0);
        check("reset_no_err", n_err, 2);
        check("reset_no_jump", n_jump, 2);
        check("final_valid_count", n_valid, 10);

        wait_neg(20);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
